layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_pkg.sv | 21 ++
 rtl/layer_sequencer_latency_counter.sv | 43 ++++
 rtl/layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// layer_sequencer_pkg
// Definitions shared by the network datapath and its control sequencer:
//   - shift-register input mux encodings (SEL_SHIFT / SEL_HOLD / SEL_LOAD)
//   - the sequencer state enumeration
// -----------------------------------------------------------------------------
package layer_sequencer_pkg;

    // Shift-register input mux select values
    localparam logic [1:0] SEL_SHIFT = 2'b00;  // shift a new data_in word in
    localparam logic [1:0] SEL_HOLD  = 2'b01;  // keep current contents
    localparam logic [1:0] SEL_LOAD  = 2'b10;  // capture neuron outputs

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_COMPUTE  = 2'd1,
        ST_FEEDBACK = 2'd2,
        ST_DRAIN    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/layer_sequencer_latency_counter.sv
// -----------------------------------------------------------------------------
// latency_counter
// Counts out the neuron settling time. A load presets the counter to
// LATENCY-1; while enabled it counts down, and done_o pulses during the
// enabled cycle in which the count sits at zero (i.e. the LATENCY-th cycle).
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous reset, active high
//   clear_i  synchronous clear (abort)
//   load_i   preset counter to LATENCY-1
//   en_i     count enable (neurons computing)
//   done_o   last cycle of the latency window
// -----------------------------------------------------------------------------
module latency_counter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);
    localparam logic [3:0] RELOAD = 4'(LATENCY - 1);

    logic [3:0] cnt_q;

    assign done_o = en_i && (cnt_q == 4'd0);

    // Count-down register; holds at zero so it can never wrap
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= RELOAD;
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Control FSM for a layered neuron network built around a 4-word shift
// register. Loads four input words, runs NUM_LAYERS compute/feedback passes,
// then drains the four result words through the output tap.
// Ports:
//   clk             rising-edge clock
//   rstn            synchronous reset, active HIGH despite the name
//   in_valid        a data_in word is presented this cycle
//   flush           synchronous abort of the running inference
//   in_ready        sequencer is in LOAD and accepts words
//   selector        shift-register input mux (00 shift, 01 hold, 10 load)
//   selector_output shift-register output tap (3,2,1,0 during DRAIN)
//   layer_idx       current layer / weight bank
//   neuron_en       neurons computing
//   out_valid       network output valid (registered, one cycle behind DRAIN)
//   busy            high whenever not in LOAD
// -----------------------------------------------------------------------------
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned NEURON_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic       flush,
    output logic       in_ready,
    output logic [1:0] selector,
    output logic [1:0] selector_output,
    output logic [1:0] layer_idx,
    output logic       neuron_en,
    output logic       out_valid,
    output logic       busy
);
    localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

    seq_state_e state_q;
    logic [1:0] load_cnt_q;
    logic [1:0] drain_cnt_q;
    logic [1:0] layer_idx_q;
    logic       out_valid_q;

    logic accept_s;
    logic lat_load_s;
    logic lat_en_s;
    logic lat_done_s;

    // flush wins over a word presented in the same cycle
    assign accept_s   = (state_q == ST_LOAD) && in_valid && !flush;
    // Preset the latency window on every entry into COMPUTE
    assign lat_load_s = (accept_s && (load_cnt_q == 2'd3)) ||
                        ((state_q == ST_FEEDBACK) && !flush && (layer_idx_q != LAST_LAYER));
    assign lat_en_s   = (state_q == ST_COMPUTE) && !flush;

    latency_counter #(
        .LATENCY (NEURON_LATENCY)
    ) u_latency_counter (
        .clk_i   (clk),
        .rst_i   (rstn),
        .clear_i (flush),
        .load_i  (lat_load_s),
        .en_i    (lat_en_s),
        .done_o  (lat_done_s)
    );

    // Datapath controls decoded from the current state
    always_comb begin
        in_ready        = 1'b0;
        busy            = 1'b1;
        neuron_en       = 1'b0;
        selector        = SEL_HOLD;
        selector_output = 2'b00;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && !flush) begin
                    selector = SEL_SHIFT;
                end else begin
                    selector = SEL_HOLD;
                end
            end
            ST_COMPUTE: begin
                neuron_en = 1'b1;
            end
            ST_FEEDBACK: begin
                if (flush) begin
                    selector = SEL_HOLD;
                end else begin
                    selector = SEL_LOAD;
                end
            end
            ST_DRAIN: begin
                // Highest word leaves first
                selector_output = 2'd3 - drain_cnt_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Sequencer state, counters and registered out_valid
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= 2'd0;
            drain_cnt_q <= 2'd0;
            layer_idx_q <= 2'd0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= 2'd0;
            drain_cnt_q <= 2'd0;
            layer_idx_q <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            // Tap is registered in the shift register, so valid trails DRAIN by one
            out_valid_q <= (state_q == ST_DRAIN);
            case (state_q)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (load_cnt_q == 2'd3) begin
                            load_cnt_q <= 2'd0;
                            state_q    <= ST_COMPUTE;
                        end else begin
                            load_cnt_q <= load_cnt_q + 2'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (lat_done_s) begin
                        state_q <= ST_FEEDBACK;
                    end
                end
                ST_FEEDBACK: begin
                    if (layer_idx_q == LAST_LAYER) begin
                        layer_idx_q <= 2'd0;
                        drain_cnt_q <= 2'd0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        layer_idx_q <= layer_idx_q + 2'd1;
                        state_q     <= ST_COMPUTE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 2'd3) begin
                        drain_cnt_q <= 2'd0;
                        state_q     <= ST_LOAD;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign layer_idx = layer_idx_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
// Table-driven bench for layer_sequencer. Two instances: defaults (3 layers,
// latency 2) and a minimal one (1 layer, latency 1). Each table row gives the
// inputs for one cycle and the expected combinational/state outputs. When a
// row completes the 4th accepted word, the expected out_valid cycles and tap
// values are pushed to a per-instance queue; a monitor compares them.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

    localparam logic [1:0] S_SHIFT = 2'b00;
    localparam logic [1:0] S_HOLD  = 2'b01;
    localparam logic [1:0] S_LOAD  = 2'b10;

    typedef struct {
        logic       iv;
        logic       fl;
        logic       rst;
        logic [1:0] sel;
        logic       rdy;
        logic       bsy;
        logic       nen;
        logic [1:0] lay;
        logic [1:0] so;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] tap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       iv_a, fl_a, rdy_a, nen_a, ov_a, busy_a;
    logic [1:0] sel_a, so_a, lay_a;
    logic       iv_b, fl_b, rdy_b, nen_b, ov_b, busy_b;
    logic [1:0] sel_b, so_b, lay_b;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic       mon_en   = 1'b0;
    vec_t       tbl[$];
    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [1:0] prev_so_a = 2'b00;
    logic [1:0] prev_so_b = 2'b00;

    layer_sequencer u_dut (
        .clk(clk), .rstn(rstn), .in_valid(iv_a), .flush(fl_a),
        .in_ready(rdy_a), .selector(sel_a), .selector_output(so_a),
        .layer_idx(lay_a), .neuron_en(nen_a), .out_valid(ov_a), .busy(busy_a)
    );

    layer_sequencer #(.NUM_LAYERS(1), .NEURON_LATENCY(1)) u_dut_small (
        .clk(clk), .rstn(rstn), .in_valid(iv_b), .flush(fl_b),
        .in_ready(rdy_b), .selector(sel_b), .selector_output(so_b),
        .layer_idx(lay_b), .neuron_en(nen_b), .out_valid(ov_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: out_valid must be high exactly on queued cycles, with the
    // tap of the previous (DRAIN) cycle matching the queued value
    always @(negedge clk) begin
        if (mon_en) begin
            if (q_a.size() > 0 && q_a[0].cyc == cyc) begin
                chk("out_valid_a", int'(ov_a), 1);
                chk("tap_a", int'(prev_so_a), int'(q_a[0].tap));
                void'(q_a.pop_front());
            end else begin
                chk("idle_out_valid_a", int'(ov_a), 0);
            end
            if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
                chk("out_valid_b", int'(ov_b), 1);
                chk("tap_b", int'(prev_so_b), int'(q_b[0].tap));
                void'(q_b.pop_front());
            end else begin
                chk("idle_out_valid_b", int'(ov_b), 0);
            end
        end
        prev_so_a = so_a;
        prev_so_b = so_b;
    end

    function automatic void add_row(input logic iv, input logic fl, input logic rst,
                                    input logic [1:0] sel, input logic rdy, input logic bsy,
                                    input logic nen, input logic [1:0] lay, input logic [1:0] so);
        vec_t v;
        v.iv = iv; v.fl = fl; v.rst = rst; v.sel = sel; v.rdy = rdy;
        v.bsy = bsy; v.nen = nen; v.lay = lay; v.so = so;
        tbl.push_back(v);
    endfunction

    function automatic void r_idle();
        add_row(1'b0, 1'b0, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    endfunction

    function automatic void r_accept();
        add_row(1'b1, 1'b0, 1'b0, S_SHIFT, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    endfunction

    function automatic void add_load(input int gap);
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) r_idle();
            r_accept();
        end
    endfunction

    // lat COMPUTE rows (in_valid optionally held high, must be ignored) + one FEEDBACK
    function automatic void add_layer(input int l, input int lat, input logic iv);
        for (int k = 0; k < lat; k++)
            add_row(iv, 1'b0, 1'b0, S_HOLD, 1'b0, 1'b1, 1'b1, 2'(l), 2'd0);
        add_row(1'b0, 1'b0, 1'b0, S_LOAD, 1'b0, 1'b1, 1'b0, 2'(l), 2'd0);
    endfunction

    function automatic void add_drain(input int first, input int n);
        for (int d = first; d < first + n; d++)
            add_row(1'b0, 1'b0, 1'b0, S_HOLD, 1'b0, 1'b1, 1'b0, 2'd0, 2'(3 - d));
    endfunction

    function automatic void add_full(input int nl, input int lat, input int gap, input logic iv);
        add_load(gap);
        for (int l = 0; l < nl; l++) add_layer(l, lat, iv);
        add_drain(0, 4);
    endfunction

    task automatic run_tbl(input string name, input int which, input int nl, input int lat);
        int         acc;
        int         latency;
        logic [8:0] act;
        logic [8:0] expv;
        exp_t       e;
        acc     = 0;
        latency = nl * (lat + 1) + 2;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rstn = tbl[i].rst;
            if (which == 0) begin
                iv_a = tbl[i].iv; fl_a = tbl[i].fl;
            end else begin
                iv_b = tbl[i].iv; fl_b = tbl[i].fl;
            end
            #1;
            expv = {tbl[i].sel, tbl[i].rdy, tbl[i].bsy, tbl[i].nen, tbl[i].lay, tbl[i].so};
            if (which == 0) act = {sel_a, rdy_a, busy_a, nen_a, lay_a, so_a};
            else            act = {sel_b, rdy_b, busy_b, nen_b, lay_b, so_b};
            chk($sformatf("%s_row%0d {sel,rdy,busy,nen,layer,tap}", name, i), int'(act), int'(expv));
            if (tbl[i].fl || tbl[i].rst) begin
                acc = 0;
                if (which == 0 || tbl[i].rst) q_a.delete();
                if (which == 1 || tbl[i].rst) q_b.delete();
            end else if (tbl[i].iv && tbl[i].rdy) begin
                acc++;
                if (acc == 4) begin
                    acc = 0;
                    for (int k = 0; k < 4; k++) begin
                        e.cyc = cyc + latency + k;
                        e.tap = 2'(3 - k);
                        if (which == 0) q_a.push_back(e);
                        else            q_b.push_back(e);
                    end
                end
            end
        end
        tbl.delete();
    endtask

    initial begin
        rstn = 1'b1;
        iv_a = 1'b0; fl_a = 1'b0;
        iv_b = 1'b0; fl_b = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Reset overrides in_valid/flush; continuous load; in_valid ignored in COMPUTE
        add_row(1'b1, 1'b1, 1'b1, S_HOLD, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        r_idle();
        add_full(3, 2, 0, 1'b1);
        r_idle();
        run_tbl("basic", 0, 3, 2);

        // in_valid every other cycle
        add_full(3, 2, 1, 1'b0);
        r_idle();
        run_tbl("pulsed", 0, 3, 2);

        // Back-to-back inferences: load resumes during the final out_valid
        add_full(3, 2, 0, 1'b0);
        add_full(3, 2, 0, 1'b1);
        r_idle();
        r_idle();
        run_tbl("b2b", 0, 3, 2);

        // flush mid-LOAD with a word presented: word dropped, load count cleared
        r_accept();
        r_accept();
        add_row(1'b1, 1'b1, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        add_full(3, 2, 0, 1'b0);
        r_idle();
        run_tbl("flush_load", 0, 3, 2);

        // flush in 2nd COMPUTE cycle of layer 1 with in_valid high
        add_load(0);
        add_layer(0, 2, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, S_HOLD, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0);
        add_row(1'b1, 1'b1, 1'b0, S_HOLD, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0);
        for (int k = 0; k < 14; k++) r_idle();
        add_full(3, 2, 0, 1'b0);
        r_idle();
        run_tbl("flush_compute", 0, 3, 2);

        // Reset during DRAIN cycle 2
        add_load(0);
        for (int l = 0; l < 3; l++) add_layer(l, 2, 1'b0);
        add_drain(0, 1);
        add_row(1'b0, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
        r_idle();
        r_idle();
        r_idle();
        add_full(3, 2, 0, 1'b0);
        r_idle();
        run_tbl("reset_drain", 0, 3, 2);

        // Minimal configuration: one layer, latency 1
        r_idle();
        add_full(1, 1, 0, 1'b1);
        add_full(1, 1, 1, 1'b0);
        r_idle();
        r_idle();
        run_tbl("small", 1, 1, 1);

        repeat (6) @(negedge clk);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
